// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the serial-in/parallel-out frame receiver.
package rx_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/rx_frame_sipo_shreg.sv
// Data shift register for the frame receiver; LSB_FIRST picks the entry end so
// the first bit shifted in ends up in bit 0 (LSB_FIRST=1) or bit W-1 (LSB_FIRST=0).
module rx_shreg #(
    parameter int W         = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         din_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sh_q;
    logic [W-1:0] sh_d;

    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign sh_d = {din_i, sh_q[W-1:1]};
        end else begin : g_msb_first
            assign sh_d = {sh_q[W-2:0], din_i};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= '0;
        end else if (en_i) begin
            sh_q <= sh_d;
        end
    end

    assign q_o = sh_q;

endmodule

// File: rtl/rx_frame_sipo.sv
// Strobe-driven UART-style frame receiver with a single-entry output holding
// register, valid/ready handshake, frame/parity error flags and overrun pulse.
module rx_frame_sipo
    import rx_frame_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int LSB_FIRST   = 1,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxin,
    input  logic              shift,
    input  logic              dready,
    output logic [DATA_W-1:0] dout,
    output logic              dvalid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);

    localparam int               CNT_W     = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);
    localparam logic             ODD_SENSE = (PARITY_MODE == PARITY_ODD);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ferr_acc_q, ferr_acc_d;
    logic              perr_acc_q, perr_acc_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dvalid_q, dvalid_d;
    logic              frame_err_q, frame_err_d;
    logic              parity_err_q, parity_err_d;
    logic              overrun_q, overrun_d;

    logic              sh_en;
    logic [DATA_W-1:0] sh_data;
    logic              complete;
    logic              ferr_new;

    rx_shreg #(
        .W         (DATA_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .en_i  (sh_en),
        .din_i (rxin),
        .q_o   (sh_data)
    );

    // Next-state: every state transition is gated by the bit-centre strobe.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ferr_acc_d = ferr_acc_q;
        perr_acc_d = perr_acc_q;
        sh_en      = 1'b0;
        complete   = 1'b0;
        ferr_new   = ferr_acc_q | ~rxin;
        if (shift) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rxin) begin
                        state_d    = ST_DATA;
                        cnt_d      = '0;
                        ferr_acc_d = 1'b0;
                        perr_acc_d = 1'b0;
                    end
                end
                ST_DATA: begin
                    sh_en = 1'b1;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    perr_acc_d = ((^sh_data) ^ rxin) != ODD_SENSE;
                    state_d    = ST_STOP;
                end
                ST_STOP: begin
                    ferr_acc_d = ferr_new;
                    if (cnt_q == STOP_LAST) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Holding register: a completed frame replaces the word only if the slot is
    // free or being accepted this cycle; otherwise the new frame is dropped.
    always_comb begin
        dout_d       = dout_q;
        dvalid_d     = dvalid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = 1'b0;
        if (complete) begin
            if (!dvalid_q || dready) begin
                dout_d       = sh_data;
                dvalid_d     = 1'b1;
                frame_err_d  = ferr_new;
                parity_err_d = perr_acc_q;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (dvalid_q && dready) begin
            dvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ferr_acc_q   <= 1'b0;
            perr_acc_q   <= 1'b0;
            dout_q       <= '0;
            dvalid_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ferr_acc_q   <= ferr_acc_d;
            perr_acc_q   <= perr_acc_d;
            dout_q       <= dout_d;
            dvalid_q     <= dvalid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dvalid     = dvalid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
